// File: rtl/counter_monitor_if.sv
// Observation bundle between the 8-bit up/down counter under watch and its monitor.
// The stimulus side drives the dut_* signals; the monitor returns its verdict signals.
interface counter_monitor_if;
  logic       dut_rst;
  logic       dut_enable;
  logic       dut_direction;
  logic [7:0] dut_counter_out;
  logic       locked;
  logic       mismatch;
  logic       err;
  logic [7:0] err_count;
  logic [7:0] expected;

  modport master (
    output dut_rst, dut_enable, dut_direction, dut_counter_out,
    input  locked, mismatch, err, err_count, expected
  );

  modport slave (
    input  dut_rst, dut_enable, dut_direction, dut_counter_out,
    output locked, mismatch, err, err_count, expected
  );
endinterface

// File: rtl/counter_monitor.sv
// Cycle-accurate checker for an 8-bit up/down counter: predicts each output from the
// previous sample and tracks mismatches, dropping lock after ERR_LIMIT in a row.
module counter_monitor #(
  parameter int ERR_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  counter_monitor_if.slave   mon
);

  localparam int CW = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT);

  typedef enum logic {UNSYNC = 1'b0, CHECK = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [7:0]      s_cnt_q;
  logic            s_rst_q, s_en_q, s_dir_q;
  logic            mismatch_q, mismatch_d;
  logic            err_q, err_d;
  logic [7:0]      err_count_q, err_count_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic [7:0]      pred;

  function automatic logic [7:0] predict(input logic r, input logic en,
                                         input logic dir, input logic [7:0] cnt);
    if (r)        return 8'h00;
    else if (!en) return cnt;
    else if (dir) return cnt + 8'd1;
    else          return cnt - 8'd1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign pred = predict(s_rst_q, s_en_q, s_dir_q, s_cnt_q);

  always_comb begin
    state_d     = state_q;
    mismatch_d  = 1'b0;
    err_d       = err_q;
    err_count_d = err_count_q;
    consec_d    = consec_q;
    case (state_q)
      UNSYNC: state_d = CHECK;
      CHECK: begin
        if (mon.dut_counter_out != pred) begin
          mismatch_d  = 1'b1;
          err_d       = 1'b1;
          err_count_d = sat_inc(err_count_q);
          // Too many misses in a row: resynchronise from the next sample.
          if (consec_q == CW'(ERR_LIMIT - 1)) begin
            consec_d = '0;
            state_d  = UNSYNC;
          end else begin
            consec_d = consec_q + CW'(1);
          end
        end else begin
          consec_d = '0;
        end
      end
      default: state_d = UNSYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNSYNC;
      s_cnt_q     <= 8'h00;
      s_rst_q     <= 1'b0;
      s_en_q      <= 1'b0;
      s_dir_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'h00;
      consec_q    <= '0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= mon.dut_counter_out;
      s_rst_q     <= mon.dut_rst;
      s_en_q      <= mon.dut_enable;
      s_dir_q     <= mon.dut_direction;
      mismatch_q  <= mismatch_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      consec_q    <= consec_d;
    end
  end

  assign mon.locked    = (state_q == CHECK);
  assign mon.mismatch  = mismatch_q;
  assign mon.err       = err_q;
  assign mon.err_count = err_count_q;
  assign mon.expected  = (state_q == CHECK) ? pred : 8'h00;

endmodule

// File: tb/tb_counter_monitor.sv
// Randomised and directed bench for counter_monitor with a transaction-level reference model.
module tb_counter_monitor;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  counter_monitor_if mon();
  counter_monitor #(.ERR_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .mon(mon));

  always #5 clk = ~clk;

  // Reference model: last observation plus the monitor's verdict history.
  int m_cnt, m_errcnt, m_consec;
  bit m_rs, m_en, m_dir, m_locked, m_mis, m_err;

  function automatic int pred();
    if (m_rs) return 0;
    if (!m_en) return m_cnt;
    if (m_dir) return (m_cnt + 1) % 256;
    return (m_cnt + 255) % 256;
  endfunction

  function automatic int m_exp();
    return m_locked ? pred() : 0;
  endfunction

  function automatic int wrong_val();
    return (pred() + int'($urandom_range(1, 255))) % 256;
  endfunction

  task automatic step(input int c, input bit r, input bit e, input bit d, input bit rs);
    mon.dut_counter_out = 8'(c);
    mon.dut_rst = r;
    mon.dut_enable = e;
    mon.dut_direction = d;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      m_locked = 0; m_mis = 0; m_err = 0; m_errcnt = 0; m_consec = 0;
      m_cnt = 0; m_rs = 0; m_en = 0; m_dir = 0;
    end else begin
      if (m_locked) begin
        if (c != pred()) begin
          m_mis = 1; m_err = 1;
          m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
          m_consec++;
          if (m_consec == LIMIT) begin
            m_locked = 0;
            m_consec = 0;
          end
        end else begin
          m_mis = 0;
          m_consec = 0;
        end
      end else begin
        m_locked = 1;
        m_mis = 0;
      end
      m_cnt = c; m_rs = r; m_en = e; m_dir = d;
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    rst = 1'b0;
    #2;
    checks++; if (mon.locked !== 1'b0) begin failures++; $display("FAIL reset_locked actual=%0d required=0", mon.locked); end
    checks++; if (mon.mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch actual=%0d required=0", mon.mismatch); end
    checks++; if (mon.err !== 1'b0) begin failures++; $display("FAIL reset_err actual=%0d required=0", mon.err); end
    checks++; if (mon.err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count actual=%0d required=0", mon.err_count); end
    checks++; if (mon.expected !== 8'd0) begin failures++; $display("FAIL reset_expected actual=%0d required=0", mon.expected); end
    // Reset wins over a simultaneous mismatch.
    step(20, 0, 1, 1, 0);
    step(77, 0, 1, 1, 1);
    checks++; if (mon.mismatch !== 1'b0 || mon.err !== 1'b0) begin failures++; $display("FAIL reset_priority actual=%0d%0d required=00", mon.mismatch, mon.err); end
    checks++; if (mon.locked !== 1'b0) begin failures++; $display("FAIL reset_priority_locked actual=%0d required=0", mon.locked); end
  endtask

  task automatic test_up_run();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i <= 10; i++) begin
      step(i, 0, 1, 1, 0);
      checks++; if (mon.locked !== 1'b1) begin failures++; $display("FAIL up_locked i=%0d actual=%0d required=1", i, mon.locked); end
      checks++; if (mon.mismatch !== 1'b0) begin failures++; $display("FAIL up_mismatch i=%0d actual=%0d required=0", i, mon.mismatch); end
      checks++; if (mon.expected !== 8'(i + 1)) begin failures++; $display("FAIL up_expected i=%0d actual=%0d required=%0d", i, mon.expected, i + 1); end
    end
    checks++; if (mon.err_count !== 8'd0) begin failures++; $display("FAIL up_err_count actual=%0d required=0", mon.err_count); end
  endtask

  task automatic test_wrap();
    int vals[4] = '{254, 255, 0, 255};
    bit dirs[4] = '{1, 1, 0, 0};
    int exps[4] = '{255, 0, 255, 254};
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(vals[i], 0, 1, dirs[i], 0);
      checks++; if (mon.expected !== 8'(exps[i])) begin failures++; $display("FAIL wrap_expected i=%0d actual=%0d required=%0d", i, mon.expected, exps[i]); end
      checks++; if (mon.mismatch !== 1'b0) begin failures++; $display("FAIL wrap_mismatch i=%0d actual=%0d required=0", i, mon.mismatch); end
    end
    checks++; if (mon.err !== 1'b0) begin failures++; $display("FAIL wrap_err actual=%0d required=0", mon.err); end
  endtask

  task automatic test_hold();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(8'h3C, 0, 0, 1, 0);
    checks++; if (mon.err !== 1'b0 || mon.expected !== 8'h3C) begin failures++; $display("FAIL hold_clean actual=err%0d/exp%0h required=err0/exp3c", mon.err, mon.expected); end
    step(8'h3D, 0, 0, 1, 0);
    checks++; if (mon.mismatch !== 1'b1) begin failures++; $display("FAIL hold_pulse actual=%0d required=1", mon.mismatch); end
    checks++; if (mon.err !== 1'b1 || mon.err_count !== 8'd1) begin failures++; $display("FAIL hold_err actual=err%0d/cnt%0d required=err1/cnt1", mon.err, mon.err_count); end
    step(8'h3D, 0, 0, 1, 0);
    checks++; if (mon.mismatch !== 1'b0) begin failures++; $display("FAIL hold_pulse_end actual=%0d required=0", mon.mismatch); end
    checks++; if (mon.err !== 1'b1 || mon.err_count !== 8'd1) begin failures++; $display("FAIL hold_sticky actual=err%0d/cnt%0d required=err1/cnt1", mon.err, mon.err_count); end
  endtask

  task automatic test_dut_reset();
    step(0, 0, 0, 0, 1);
    step(8'h7E, 0, 1, 1, 0);
    step(8'h7F, 0, 1, 1, 0);
    step(8'h80, 1, 1, 1, 0);
    checks++; if (mon.expected !== 8'h00) begin failures++; $display("FAIL dutrst_expected actual=%0d required=0", mon.expected); end
    step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    checks++; if (mon.mismatch !== 1'b0 || mon.err !== 1'b0) begin failures++; $display("FAIL dutrst_clean actual=%0d%0d required=00", mon.mismatch, mon.err); end
  endtask

  task automatic test_lock_loss();
    step(0, 0, 0, 0, 1);
    step(10, 0, 1, 1, 0);
    step(11, 0, 1, 1, 0);
    for (int i = 0; i < LIMIT; i++) begin
      step(wrong_val(), 0, 1, 1, 0);
      checks++; if (mon.mismatch !== 1'b1) begin failures++; $display("FAIL loss_pulse i=%0d actual=%0d required=1", i, mon.mismatch); end
    end
    checks++; if (mon.err_count !== 8'(LIMIT) || mon.locked !== 1'b0) begin failures++; $display("FAIL loss_state actual=cnt%0d/lock%0d required=cnt%0d/lock0", mon.err_count, mon.locked, LIMIT); end
    checks++; if (mon.expected !== 8'd0) begin failures++; $display("FAIL loss_expected actual=%0d required=0", mon.expected); end
    step($urandom_range(0, 255), 0, 1, 1, 0);
    checks++; if (mon.locked !== 1'b1) begin failures++; $display("FAIL relock actual=%0d required=1", mon.locked); end
    for (int i = 0; i < 6; i++) step(pred(), 0, 1, 1, 0);
    checks++; if (mon.err_count !== 8'(LIMIT) || mon.mismatch !== 1'b0) begin failures++; $display("FAIL relock_clean actual=cnt%0d/mis%0d required=cnt%0d/mis0", mon.err_count, mon.mismatch, LIMIT); end
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      step(wrong_val(), 0, 1, $urandom_range(0, 1), 0);
      checks++; if (mon.err_count !== 8'(m_errcnt)) begin failures++; $display("FAIL sat_count i=%0d actual=%0d required=%0d", i, mon.err_count, m_errcnt); end
    end
    checks++; if (mon.err_count !== 8'd255) begin failures++; $display("FAIL sat_final actual=%0d required=255", mon.err_count); end
    step(wrong_val(), 0, 1, 1, 1);
    checks++; if (mon.err_count !== 8'd0 || mon.err !== 1'b0 || mon.locked !== 1'b0 || mon.mismatch !== 1'b0 || mon.expected !== 8'd0)
      begin failures++; $display("FAIL sat_reset actual=cnt%0d/err%0d/lock%0d/mis%0d/exp%0d required=all0", mon.err_count, mon.err, mon.locked, mon.mismatch, mon.expected); end
  endtask

  task automatic test_random();
    int c;
    bit rs;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      if (m_locked && $urandom_range(0, 7) != 0) c = pred();
      else if (m_locked) c = wrong_val();
      else c = $urandom_range(0, 255);
      step(c, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1), rs);
      checks++;
      if (mon.locked !== m_locked || mon.mismatch !== m_mis || mon.err !== m_err ||
          mon.err_count !== 8'(m_errcnt) || mon.expected !== 8'(m_exp()))
        begin
          failures++;
          $display("FAIL random i=%0d actual=lock%0d/mis%0d/err%0d/cnt%0d/exp%0d required=lock%0d/mis%0d/err%0d/cnt%0d/exp%0d",
                   i, mon.locked, mon.mismatch, mon.err, mon.err_count, mon.expected,
                   m_locked, m_mis, m_err, m_errcnt, m_exp());
        end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mon.dut_rst = 1'b0;
    mon.dut_enable = 1'b0;
    mon.dut_direction = 1'b0;
    mon.dut_counter_out = 8'h00;
    test_reset();
    test_up_run();
    test_wrap();
    test_hold();
    test_dut_reset();
    test_lock_loss();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter ERR_LIMIT, default 4: consecutive mismatches that force a loss of lock.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset of the monitor itself.
REQ-004 dut_rst  input  1  observed reset driven to the 8-bit up/down counter.
REQ-005 dut_enable  input  1  observed counter enable.
REQ-006 dut_direction  input  1  observed direction: 1 = up, 0 = down.
REQ-007 dut_counter_out  input  8  observed counter output.
REQ-008 locked  output  1  high while the monitor holds a valid prediction.
REQ-009 mismatch  output  1  one-cycle pulse per failed comparison.
REQ-010 err  output  1  sticky error flag.
REQ-011 err_count  output  8  saturating total of mismatches.
REQ-012 expected  output  8  value predicted for the current dut_counter_out.

Function
REQ-013 Sample registers s_cnt, s_rst, s_en and s_dir SHALL capture dut_counter_out, dut_rst, dut_enable and dut_direction on every edge, in every state.
REQ-014 Prediction SHALL be: s_rst=1 -> 0; else s_en=0 -> s_cnt; else s_dir=1 -> s_cnt+1 mod 256; else s_cnt-1 mod 256.
REQ-015 Reset has priority over enable: s_rst=1 predicts 0 regardless of s_en and s_dir.
REQ-016 Wrap-around: 255 up -> 0 and 0 down -> 255 are legal transitions, not errors.
REQ-017 expected SHALL combinationally show the REQ-014 prediction, and SHALL read 0 in UNSYNC.
REQ-018 FSM states: UNSYNC and CHECK.
REQ-019 UNSYNC: no comparison; go to CHECK on the next edge (one sample captured).
REQ-020 CHECK: on each edge, compare the prediction with the current dut_counter_out.
REQ-021 Mismatch in CHECK: mismatch=1 for exactly the following cycle, err set, err_count incremented, consecutive-mismatch counter incremented.
REQ-022 Match in CHECK: mismatch=0 and the consecutive-mismatch counter is cleared.
REQ-023 err_count SHALL saturate at 255 and never wrap.
REQ-024 err SHALL stay set until rst.
REQ-025 When the consecutive-mismatch counter reaches ERR_LIMIT, CHECK -> UNSYNC on the same edge and the counter clears; err and err_count are retained.
REQ-026 After a mismatch, the next prediction SHALL be based on the observed value, not the failed prediction.
REQ-027 locked SHALL be 1 exactly when the state is CHECK.
REQ-028 A dut_rst assertion mid-count is normal stimulus: the next sample SHALL predict 0 with no error if the DUT reads 0.

Reset
REQ-029 rst=1 at an edge SHALL set: state UNSYNC, locked=0, mismatch=0, err=0, err_count=0, consecutive counter 0, all sample registers 0.
REQ-030 rst SHALL override every other event on the same edge, including a mismatch and ERR_LIMIT detection.
REQ-031 Outputs SHALL hold their reset values until the first edge after rst deasserts.

Verification
REQ-032 Up run: dut_enable=1, dut_direction=1, DUT counting 0..10 -> locked=1 from the 2nd edge, mismatch never asserted, err_count=0.
REQ-033 Wrap: DUT 254,255,0 up, then 0,255 down -> no mismatch, expected tracks 255, 0, 255.
REQ-034 Hold: dut_enable=0 with DUT held at 0x3C for 5 cycles -> no error; one forced value 0x3D -> single mismatch pulse, err=1, err_count=1.
REQ-035 DUT reset mid-count: DUT at 0x80, dut_rst=1 for 1 cycle, DUT reads 0 next -> no mismatch.
REQ-036 Lock loss: 4 consecutive wrong values with ERR_LIMIT=4 -> err_count=4, locked=0 for one cycle, then relock, no further errors on correct data.
REQ-037 Saturation and reset: 300 forced mismatches -> err_count=255; rst=1 -> all outputs return to the REQ-029 values on the next edge.
